mct_controller: RTL and testbench

Memory-cycle-time (MCT) controller for the simulator's timing chain. Consumes the eleven timing pulses from the sequence generator and, once per MCT, grants the erasable-memory datapath to one requester: the instruction sequencer or one of several involuntary counter-increment cells. It then issues single-clock address-load, read, increment, write and done strobes at fixed timing-pulse positions within the MCT.

---
 rtl/mct_controller.sv | 147 ++++++++++++++
 tb/tb_mct_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mct_controller.sv
// Memory-cycle-time controller: arbitrates one erasable-memory cycle per MCT and
// issues registered one-clock strobes at TP1/TP4/TP7/TP10/TP11 rise positions.
module mct_controller #(
  parameter int          NUM_CNT     = 4,
  parameter logic [11:0] CNT_BASE    = 12'h014,
  parameter int          MAX_CNT_RUN = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [10:0]        tp,
  input  logic               inst_req,
  input  logic [11:0]        inst_addr,
  input  logic               inst_we,
  input  logic [NUM_CNT-1:0] cnt_req,
  output logic [11:0]        mem_addr,
  output logic               addr_load,
  output logic               rd_pulse,
  output logic               inc_pulse,
  output logic               wr_pulse,
  output logic               inst_ack,
  output logic [NUM_CNT-1:0] cnt_ack,
  output logic               busy,
  output logic               seq_err
);

  localparam int IW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam int RW = ($clog2(MAX_CNT_RUN + 1) < 2) ? 2 : $clog2(MAX_CNT_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_CNT_RUN);

  typedef enum logic [2:0] {IDLE, ADDR, READ, MOD, WRITE} state_t;

  state_t             state, state_nxt;
  logic [10:0]        tp_q;
  logic [10:0]        rise;
  logic [NUM_CNT-1:0] pend;
  logic [RW-1:0]      run_cnt;
  logic               is_cnt;
  logic               cyc_we;
  logic [IW-1:0]      idx;
  logic               any_pend;
  logic [IW-1:0]      low_idx;
  logic               grant, grant_cnt, abort;
  logic               al_n, rd_n, inc_n, wr_n, iack_n;
  logic [NUM_CNT-1:0] cack_n;
  logic               unused_rise;

  assign rise        = tp & ~tp_q;
  assign unused_rise = ^{rise[8:7], rise[5:4], rise[2:1]};

  always_comb begin
    any_pend = |pend;
    low_idx  = '0;
    for (int i = NUM_CNT - 1; i >= 0; i--) begin
      if (pend[i]) low_idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A TP1 rise always starts a new MCT; if one was still in flight it is aborted unacknowledged.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_cnt = 1'b0;
    abort     = 1'b0;
    al_n      = 1'b0;
    rd_n      = 1'b0;
    inc_n     = 1'b0;
    wr_n      = 1'b0;
    iack_n    = 1'b0;
    cack_n    = '0;
    if (rise[0]) begin
      abort     = (state != IDLE);
      state_nxt = IDLE;
      if (run_cnt == RUN_MAX && inst_req) begin
        grant = 1'b1;
      end else if (any_pend) begin
        grant     = 1'b1;
        grant_cnt = 1'b1;
      end else if (inst_req) begin
        grant = 1'b1;
      end
      if (grant) begin
        state_nxt = ADDR;
        al_n      = 1'b1;
      end
    end else begin
      case (state)
        ADDR:  if (rise[3]) begin rd_n = 1'b1; state_nxt = READ; end
        READ:  if (rise[6]) begin inc_n = is_cnt; state_nxt = MOD; end
        MOD:   if (rise[9]) begin wr_n = cyc_we; state_nxt = WRITE; end
        WRITE: if (rise[10]) begin
          iack_n    = ~is_cnt;
          cack_n    = is_cnt ? (NUM_CNT'(1) << idx) : '0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tp_q      <= '0;
      pend      <= '0;
      run_cnt   <= '0;
      mem_addr  <= '0;
      is_cnt    <= 1'b0;
      cyc_we    <= 1'b0;
      idx       <= '0;
      addr_load <= 1'b0;
      rd_pulse  <= 1'b0;
      inc_pulse <= 1'b0;
      wr_pulse  <= 1'b0;
      inst_ack  <= 1'b0;
      cnt_ack   <= '0;
      busy      <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      tp_q      <= tp;
      addr_load <= al_n;
      rd_pulse  <= rd_n;
      inc_pulse <= inc_n;
      wr_pulse  <= wr_n;
      inst_ack  <= iack_n;
      cnt_ack   <= cack_n;
      busy      <= (state_nxt != IDLE);
      seq_err   <= seq_err | abort;
      // Clear uses the visible ack so a request arriving in the ack clock survives.
      pend      <= (pend & ~cnt_ack) | cnt_req;
      if (grant) begin
        mem_addr <= grant_cnt ? (CNT_BASE + 12'(low_idx)) : inst_addr;
        is_cnt   <= grant_cnt;
        idx      <= low_idx;
        cyc_we   <= grant_cnt | inst_we;
        if (grant_cnt && inst_req)
          run_cnt <= (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RW'(1);
        else
          run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mct_controller.sv
// Directed bench for mct_controller: drives 20-clock pulse trains and compares
// per-MCT strobe position masks against hand-derived constants.
module tb_mct_controller;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] tp;
  logic        inst_req;
  logic [11:0] inst_addr;
  logic        inst_we;
  logic [3:0]  cnt_req;
  logic [11:0] mem_addr;
  logic        addr_load, rd_pulse, inc_pulse, wr_pulse, inst_ack, busy, seq_err;
  logic [3:0]  cnt_ack;

  always #5 clk = ~clk;

  mct_controller dut (
    .clk(clk), .reset_n(reset_n), .tp(tp), .inst_req(inst_req),
    .inst_addr(inst_addr), .inst_we(inst_we), .cnt_req(cnt_req),
    .mem_addr(mem_addr), .addr_load(addr_load), .rd_pulse(rd_pulse),
    .inc_pulse(inc_pulse), .wr_pulse(wr_pulse), .inst_ack(inst_ack),
    .cnt_ack(cnt_ack), .busy(busy), .seq_err(seq_err)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-MCT record: bit n of each mask = strobe seen high in clock offset n.
  logic [19:0] m_al, m_rd, m_inc, m_wr, m_ia, m_ca, m_busy;
  logic [3:0]  ca_or;
  logic [11:0] addr0;
  logic        rst_any;

  // TP1..TP9 start at 2*(k-1), TP10 at 17, TP11 at 18; each two clocks wide.
  function automatic logic [10:0] tp_at(input int off, input bit drop11);
    logic [10:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) if (off >= 2 * k && off < 2 * k + 2) v[k] = 1'b1;
    if (off == 17 || off == 18) v[9] = 1'b1;
    if ((off == 18 || off == 19) && !drop11) v[10] = 1'b1;
    return v;
  endfunction

  task automatic mct(input bit drop11 = 1'b0, input int rst_off = -1,
                     input int cr_off = -1, input logic [3:0] cr_val = 4'b0);
    m_al = '0; m_rd = '0; m_inc = '0; m_wr = '0; m_ia = '0; m_ca = '0; m_busy = '0;
    ca_or = '0; addr0 = '0; rst_any = 1'b0;
    for (int off = 0; off < 20; off++) begin
      @(negedge clk);
      tp      = tp_at(off, drop11);
      cnt_req = (off == cr_off) ? cr_val : 4'b0;
      reset_n = (off == rst_off) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      m_al[off]   = addr_load;
      m_rd[off]   = rd_pulse;
      m_inc[off]  = inc_pulse;
      m_wr[off]   = wr_pulse;
      m_ia[off]   = inst_ack;
      m_ca[off]   = |cnt_ack;
      m_busy[off] = busy;
      ca_or       = ca_or | cnt_ack;
      if (off == 0) addr0 = mem_addr;
      if (off == rst_off)
        rst_any = addr_load | rd_pulse | inc_pulse | wr_pulse | inst_ack |
                  (|cnt_ack) | busy | seq_err | (|mem_addr);
    end
  endtask

  task automatic pulse_req(input logic [3:0] v);
    @(negedge clk);
    tp      = '0;
    cnt_req = v;
    @(negedge clk);
    cnt_req = '0;
  endtask

  task automatic exp_full(input string t, input logic [11:0] a, input bit inc,
                          input bit wr, input bit ia, input logic [3:0] ca);
    chk({t, ".addr"}, 32'(addr0), 32'(a));
    chk({t, ".addr_load"}, 32'(m_al), 32'h00001);
    chk({t, ".rd"}, 32'(m_rd), 32'h00040);
    chk({t, ".inc"}, 32'(m_inc), inc ? 32'h01000 : 32'h0);
    chk({t, ".wr"}, 32'(m_wr), wr ? 32'h20000 : 32'h0);
    chk({t, ".inst_ack"}, 32'(m_ia), ia ? 32'h40000 : 32'h0);
    chk({t, ".cnt_ack"}, 32'(ca_or), 32'(ca));
    chk({t, ".cnt_ack_pos"}, 32'(m_ca), (ca != 4'b0) ? 32'h40000 : 32'h0);
    chk({t, ".busy"}, 32'(m_busy), 32'h3FFFF);
  endtask

  task automatic exp_idle(input string t);
    chk({t, ".addr_load"}, 32'(m_al), 32'h0);
    chk({t, ".busy"}, 32'(m_busy), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; tp = '0; inst_req = 1'b0; inst_addr = '0; inst_we = 1'b0; cnt_req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.seq_err", 32'(seq_err), 32'h0);
    chk("rst.addr_load", 32'(addr_load), 32'h0);
    chk("rst.mem_addr", 32'(mem_addr), 32'h0);
    chk("rst.cnt_ack", 32'(cnt_ack), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Instruction read.
    inst_req = 1'b1; inst_addr = 12'h123; inst_we = 1'b0;
    mct();
    exp_full("iread", 12'h123, 1'b0, 1'b0, 1'b1, 4'b0);
    inst_req = 1'b0;

    // Counter 2 cycle, then pend[2] must be gone.
    pulse_req(4'b0100);
    mct();
    exp_full("cnt2", 12'h016, 1'b1, 1'b1, 1'b0, 4'b0100);
    mct();
    exp_idle("cnt2_clear");

    // Instruction write.
    inst_req = 1'b1; inst_addr = 12'h3AB; inst_we = 1'b1;
    mct();
    exp_full("iwrite", 12'h3AB, 1'b0, 1'b1, 1'b1, 4'b0);

    // Priority and starvation limit.
    inst_addr = 12'h200; inst_we = 1'b0;
    pulse_req(4'b1111);
    mct(); exp_full("prio0.c0", 12'h014, 1'b1, 1'b1, 1'b0, 4'b0001);
    mct(); exp_full("prio1.c1", 12'h015, 1'b1, 1'b1, 1'b0, 4'b0010);
    mct(); exp_full("prio2.c2", 12'h016, 1'b1, 1'b1, 1'b0, 4'b0100);
    mct(); exp_full("prio3.instr", 12'h200, 1'b0, 1'b0, 1'b1, 4'b0);
    mct(); exp_full("prio4.c3", 12'h017, 1'b1, 1'b1, 1'b0, 4'b1000);
    mct(); exp_full("prio5.instr", 12'h200, 1'b0, 1'b0, 1'b1, 4'b0);
    inst_req = 1'b0;

    // Set/clear collision: request lands in the cnt_ack clock.
    pulse_req(4'b0001);
    mct(1'b0, -1, 19, 4'b0001);
    exp_full("coll.first", 12'h014, 1'b1, 1'b1, 1'b0, 4'b0001);
    mct();
    exp_full("coll.again", 12'h014, 1'b1, 1'b1, 1'b0, 4'b0001);
    mct();
    exp_idle("coll.done");

    // Malformed: TP11 dropped, next TP1 arrives in WRITE.
    pulse_req(4'b0010);
    mct(1'b1);
    chk("mal.addr", 32'(addr0), 32'h015);
    chk("mal.wr", 32'(m_wr), 32'h20000);
    chk("mal.no_ack", 32'(ca_or), 32'h0);
    chk("mal.busy", 32'(m_busy), 32'hFFFFF);
    chk("mal.seq_err_pre", 32'(seq_err), 32'h0);
    mct();
    exp_full("mal.regrant", 12'h015, 1'b1, 1'b1, 1'b0, 4'b0010);
    chk("mal.seq_err", 32'(seq_err), 32'h1);
    mct();
    exp_idle("mal.idle");
    chk("mal.seq_err_sticky", 32'(seq_err), 32'h1);

    // Reset in READ.
    pulse_req(4'b0010);
    mct(1'b0, 8);
    chk("rmid.addr", 32'(addr0), 32'h015);
    chk("rmid.addr_load", 32'(m_al), 32'h00001);
    chk("rmid.rd", 32'(m_rd), 32'h00040);
    chk("rmid.inc", 32'(m_inc), 32'h0);
    chk("rmid.wr", 32'(m_wr), 32'h0);
    chk("rmid.no_ack", 32'(ca_or), 32'h0);
    chk("rmid.busy", 32'(m_busy), 32'h000FF);
    chk("rmid.outs_zero", 32'(rst_any), 32'h0);
    chk("rmid.seq_err", 32'(seq_err), 32'h0);
    mct();
    exp_idle("rmid.pend_clear");
    inst_req = 1'b1; inst_addr = 12'h055; inst_we = 1'b1;
    mct();
    exp_full("rmid.recover", 12'h055, 1'b0, 1'b1, 1'b1, 4'b0);
    inst_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
